// File: rtl/memory_stage.sv
// RV32I memory stage: formats load/store requests to the data memory port and
// registers the completed instruction, ALU result and extended load data for writeback.
module memory_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] alu_result_o,
  output logic [31:0] data_o,
  output logic        misalign_o
);

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] WAIT_RESP = 1'b1;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic [0:0]  state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] data_q, data_d;
  logic        misalign_q, misalign_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [1:0]  addr_lo;
  logic        is_load_op, is_store_op, is_mem_op;
  logic        legal, misaligned, mem_ok, complete;

  // Lane-select then sign- or zero-extend the returned word.
  function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                              input logic [1:0]  a,
                                              input logic [31:0] rd);
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] r_s;
    b_s = rd[{a, 3'b000} +: 8];
    h_s = a[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  r_s = b_s;
      3'b001:  r_s = h_s;
      3'b100:  r_s = $signed({24'b0, b_s});
      3'b101:  r_s = $signed({16'b0, h_s});
      default: r_s = $signed(rd);
    endcase
    return $unsigned(r_s);
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] sd);
    case (size)
      2'b00:   return {4{sd[7:0]}};
      2'b01:   return {2{sd[15:0]}};
      default: return sd;
    endcase
  endfunction

  assign opcode      = instr_i[6:0];
  assign funct3      = instr_i[14:12];
  assign addr_lo     = alu_result_i[1:0];
  assign is_load_op  = (opcode == OP_LOAD);
  assign is_store_op = (opcode == OP_STORE);
  assign is_mem_op   = is_load_op | is_store_op;

  always_comb begin
    legal = 1'b0;
    if (is_load_op)
      legal = (funct3 == 3'b000) | (funct3 == 3'b001) | (funct3 == 3'b010) |
              (funct3 == 3'b100) | (funct3 == 3'b101);
    else if (is_store_op)
      legal = (funct3 == 3'b000) | (funct3 == 3'b001) | (funct3 == 3'b010);
  end

  assign misaligned = ((funct3[1:0] == 2'b01) & addr_lo[0]) |
                      ((funct3[1:0] == 2'b10) & (addr_lo != 2'b00));
  assign mem_ok     = valid_i & legal & !misaligned;

  assign dmem_we_o    = dmem_req_o & is_store_op;
  assign dmem_addr_o  = {alu_result_i[31:2], 2'b00};
  assign dmem_be_o    = byte_enables(funct3[1:0], addr_lo);
  assign dmem_wdata_o = store_lanes(funct3[1:0], store_data_i);

  always_comb begin
    state_d    = state_q;
    stall_o    = 1'b0;
    dmem_req_o = 1'b0;
    complete   = 1'b0;
    if (state_q == IDLE) begin
      dmem_req_o = mem_ok;
      stall_o    = mem_ok & (is_load_op | !dmem_gnt_i);
      complete   = valid_i & (!is_mem_op | (mem_ok & is_store_op & dmem_gnt_i));
      if (mem_ok & is_load_op & dmem_gnt_i)
        state_d = WAIT_RESP;
    end else begin
      stall_o  = !dmem_rvalid_i;
      complete = dmem_rvalid_i;
      if (dmem_rvalid_i)
        state_d = IDLE;
    end
    // Reset masks the handshake so nothing is requested or stalled while it is held.
    if (rst) begin
      dmem_req_o = 1'b0;
      stall_o    = 1'b0;
    end
  end

  always_comb begin
    instr_d    = complete ? instr_i : 32'h0;
    alu_d      = complete ? alu_result_i : 32'h0;
    data_d     = (complete && state_q == WAIT_RESP) ?
                 load_extend(funct3, addr_lo, dmem_rdata_i) : 32'h0;
    misalign_d = (state_q == IDLE) & valid_i & legal & misaligned;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      instr_q    <= 32'h0;
      alu_q      <= 32'h0;
      data_q     <= 32'h0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      alu_q      <= alu_d;
      data_q     <= data_d;
      misalign_q <= misalign_d;
    end
  end

  assign instr_o      = instr_q;
  assign alu_result_o = alu_q;
  assign data_o       = data_q;
  assign misalign_o   = misalign_q;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed and random loads/stores checked against a
// byte-level reference model of RV32I memory access rules.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [31:0] instr_i, alu_result_i, store_data_i;
  logic        stall_o, dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic [31:0] instr_o, alu_result_o, data_o;
  logic        misalign_o;

  int n_checks = 0;
  int n_pass   = 0;

  memory_stage dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .instr_i(instr_i),
    .alu_result_i(alu_result_i), .store_data_i(store_data_i),
    .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .instr_o(instr_o), .alu_result_o(alu_result_o), .data_o(data_o),
    .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [31:0] ADD_X3  = 32'h002081B3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference model: 0 = non-memory, 1 = load, 2 = store, 3 = illegal memory op.
  function automatic int classify(input logic [31:0] ins);
    int f3;
    f3 = int'(ins[14:12]);
    if (ins[6:0] == OP_LOAD)
      return (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) ? 1 : 3;
    if (ins[6:0] == OP_STORE)
      return (f3 <= 2) ? 2 : 3;
    return 0;
  endfunction

  function automatic int nbytes(input logic [31:0] ins);
    return 1 << int'(ins[13:12]);
  endfunction

  function automatic logic [3:0] model_be(input int n, input logic [31:0] addr);
    logic [3:0] be;
    int a;
    a = int'(addr % 4);
    for (int k = 0; k < 4; k++) be[k] = (k >= a) && (k < a + n);
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input int n, input logic [31:0] sd);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = sd[8*(k % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] ins, input logic [31:0] addr,
                                             input logic [31:0] rd);
    longint v, span;
    int n;
    n    = nbytes(ins);
    span = longint'(1) << (8 * n);
    v    = (longint'(rd) >> (8 * int'(addr % 4))) % span;
    if (!ins[14] && n < 4 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  task automatic expect_out(input string tag, input logic [31:0] ins, input logic [31:0] alu,
                            input logic [31:0] dat, input logic mis);
    check({tag, ".instr_o"}, instr_o, ins);
    check({tag, ".alu_result_o"}, alu_result_o, alu);
    check({tag, ".data_o"}, data_o, dat);
    check({tag, ".misalign_o"}, 32'(misalign_o), 32'(mis));
  endtask

  task automatic idle_cycles(input int n);
    valid_i = 1'b0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      check("idle.req", 32'(dmem_req_o), 32'd0);
      check("idle.stall", 32'(stall_o), 32'd0);
      @(posedge clk); #1;
      expect_out("idle", 32'h0, 32'h0, 32'h0, 1'b0);
    end
  endtask

  // Present one instruction, play the memory side with the given grant delay and
  // rvalid latency, and check every cycle until it leaves the stage.
  task automatic do_op(input string tag, input logic [31:0] ins, input logic [31:0] addr,
                       input logic [31:0] sd, input int gd, input int rl, input logic [31:0] rdat);
    int  kind, n;
    bit  mis, ok, last;
    kind = classify(ins);
    n    = (kind == 1 || kind == 2) ? nbytes(ins) : 1;
    mis  = (kind == 1 || kind == 2) && (addr % n != 0);
    ok   = (kind == 1 || kind == 2) && !mis;
    valid_i = 1'b1; instr_i = ins; alu_result_i = addr; store_data_i = sd;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = rdat;
    if (ok) begin
      for (int c = 0; c <= gd; c++) begin
        last = (c == gd);
        dmem_gnt_i = last;
        @(negedge clk);
        check({tag, ".req"}, 32'(dmem_req_o), 32'd1);
        check({tag, ".we"}, 32'(dmem_we_o), 32'(kind == 2));
        check({tag, ".addr"}, dmem_addr_o, addr & ~32'h3);
        check({tag, ".be"}, 32'(dmem_be_o), 32'(model_be(n, addr)));
        if (kind == 2) check({tag, ".wdata"}, dmem_wdata_o, model_wdata(n, sd));
        check({tag, ".stall"}, 32'(stall_o), 32'((kind == 1) || !last));
        @(posedge clk); #1;
        if (kind == 2 && last) expect_out(tag, ins, addr, 32'h0, 1'b0);
        else                   expect_out({tag, ".bubble"}, 32'h0, 32'h0, 32'h0, 1'b0);
      end
      if (kind == 1) begin
        dmem_gnt_i = 1'b0;
        for (int c = 1; c <= rl; c++) begin
          last = (c == rl);
          dmem_rvalid_i = last;
          @(negedge clk);
          check({tag, ".wait_req"}, 32'(dmem_req_o), 32'd0);
          check({tag, ".wait_stall"}, 32'(stall_o), 32'(!last));
          @(posedge clk); #1;
          if (last) expect_out(tag, ins, addr, model_load(ins, addr, rdat), 1'b0);
          else      expect_out({tag, ".bubble"}, 32'h0, 32'h0, 32'h0, 1'b0);
        end
      end
    end else begin
      @(negedge clk);
      check({tag, ".req"}, 32'(dmem_req_o), 32'd0);
      check({tag, ".stall"}, 32'(stall_o), 32'd0);
      @(posedge clk); #1;
      if (kind == 0) expect_out(tag, ins, addr, 32'h0, 1'b0);
      else           expect_out(tag, 32'h0, 32'h0, 32'h0, mis);
    end
    valid_i = 1'b0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] op,
                                     input logic [31:0] r);
    return {r[31:15], f3, r[11:7], op};
  endfunction

  initial begin
    rst = 1'b1; valid_i = 1'b0; instr_i = '0; alu_result_i = '0; store_data_i = '0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;

    // Reset held two cycles; a valid store presented under reset must not request.
    @(posedge clk); #1;
    valid_i = 1'b1; instr_i = mk(3'b010, OP_STORE, 32'h0); alu_result_i = 32'h100;
    @(negedge clk);
    check("rst.req", 32'(dmem_req_o), 32'd0);
    check("rst.stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    expect_out("rst", 32'h0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;
    idle_cycles(2);

    // Stores: delayed-grant SB, immediate-grant SW.
    do_op("sb", mk(3'b000, OP_STORE, 32'h0), 32'h1003, 32'hAABBCCDD, 2, 1, 32'h0);
    do_op("sw", mk(3'b010, OP_STORE, 32'h0), 32'h2000, 32'h12345678, 0, 1, 32'h0);

    // Sign- and zero-extended loads from the same word.
    do_op("lb",  mk(3'b000, OP_LOAD, 32'h0), 32'h12, 32'h0, 0, 1, 32'h0080FF00);
    do_op("lhu", mk(3'b101, OP_LOAD, 32'h0), 32'h12, 32'h0, 0, 1, 32'h0080FF00);
    check("lhu.value", data_o, 32'h00000080);

    // Misaligned accesses pulse misalign_o for one cycle only.
    do_op("lw_mis", mk(3'b010, OP_LOAD, 32'h0), 32'h102, 32'h0, 0, 1, 32'h0);
    do_op("sh_mis", mk(3'b001, OP_STORE, 32'h0), 32'h5, 32'h0, 0, 1, 32'h0);
    idle_cycles(1);
    do_op("lw_f3_3", mk(3'b011, OP_LOAD, 32'h0), 32'h8, 32'h0, 0, 1, 32'h0);

    // Reset while a load is outstanding; the stray rvalid afterwards is ignored.
    valid_i = 1'b1; instr_i = mk(3'b010, OP_LOAD, 32'h0); alu_result_i = 32'h40;
    dmem_gnt_i = 1'b1; dmem_rdata_i = 32'hDEADBEEF;
    @(posedge clk); #1;
    dmem_gnt_i = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("midrst.req", 32'(dmem_req_o), 32'd0);
    check("midrst.stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    expect_out("midrst", 32'h0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0; valid_i = 1'b0; dmem_rvalid_i = 1'b1;
    @(negedge clk);
    check("stray.stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    expect_out("stray", 32'h0, 32'h0, 32'h0, 1'b0);
    dmem_rvalid_i = 1'b0;
    do_op("post_rst_add", ADD_X3, 32'h77, 32'h0, 0, 1, 32'h0);

    // Mixed stream back-to-back: ADD, LW (rvalid 3 cycles after grant), ADD.
    do_op("mix_add1", ADD_X3, 32'h11, 32'h0, 0, 1, 32'h0);
    do_op("mix_lw", mk(3'b010, OP_LOAD, 32'h0), 32'h300, 32'h0, 0, 3, 32'hCAFEF00D);
    do_op("mix_add2", ADD_X3 ^ 32'h00100000, 32'h22, 32'h0, 0, 1, 32'h0);

    // Random mix of loads, stores, illegal and ALU ops with varying memory latency.
    for (int i = 0; i < 60; i++) begin
      logic [31:0] r, addr, sd, rd, ins;
      int sel;
      r    = $urandom();
      addr = $urandom();
      sd   = $urandom();
      rd   = $urandom();
      sel  = int'($urandom_range(0, 2));
      ins  = mk(3'($urandom_range(0, 7)),
                (sel == 0) ? OP_LOAD : (sel == 1) ? OP_STORE : 7'b0110011, r);
      do_op("rand", ins, addr, sd, int'($urandom_range(0, 2)), int'($urandom_range(1, 3)), rd);
      if ($urandom_range(0, 3) == 0) idle_cycles(1);
    end

    idle_cycles(1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
